// File: rtl/max_min_n_finder_pkg.sv
// Shared state encoding and sizing helpers for max_min_n_finder.
package max_min_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'b001;
  localparam logic [ST_W-1:0] ST_SCAN = 3'b010;
  localparam logic [ST_W-1:0] ST_DONE = 3'b100;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = ST_IDLE,
    S_SCAN = ST_SCAN,
    S_DONE = ST_DONE
  } state_e;

  // Count register must hold the value N itself, hence the extra bit.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/max_min_n_finder_cmp.sv
// Strict greater/less comparator, unsigned or two's-complement by SIGNED.
module max_min_cmp #(
  parameter int W      = 3,
  parameter int SIGNED = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_gt_b,
  output logic         a_lt_b
);

  generate
    if (SIGNED != 0) begin : g_signed
      assign a_gt_b = $signed(a) > $signed(b);
      assign a_lt_b = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign a_gt_b = a > b;
      assign a_lt_b = a < b;
    end
  endgenerate

endmodule

// File: rtl/max_min_n_finder.sv
// Streaming running max/min over N operands with start/ack/abort handshake.
// Define MAX_MIN_INDEX_EN to add max_idx/min_idx position outputs.
module max_min_n_finder
  import max_min_pkg::*;
#(
  parameter int W      = 3,
  parameter int N      = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ack,
  input  logic                  abort,
  input  logic                  din_valid,
  input  logic [W-1:0]          din,
  output logic                  din_ready,
  output logic [W-1:0]          max,
  output logic [W-1:0]          min,
  output logic [cnt_w(N)-1:0]   cnt,
  output logic                  busy,
  output logic                  done,
`ifdef MAX_MIN_INDEX_EN
  output logic [$clog2(N)-1:0]  max_idx,
  output logic [$clog2(N)-1:0]  min_idx,
`endif
  output logic [ST_W-1:0]       state
);

  localparam int CW = cnt_w(N);

  state_e state_q;
  logic   din_gt_max, din_lt_min;
  logic   unused_lt_max, unused_gt_min;
  logic   upd_max, upd_min;

  max_min_cmp #(.W(W), .SIGNED(SIGNED)) u_cmp_max (
    .a      (din),
    .b      (max),
    .a_gt_b (din_gt_max),
    .a_lt_b (unused_lt_max)
  );

  max_min_cmp #(.W(W), .SIGNED(SIGNED)) u_cmp_min (
    .a      (din),
    .b      (min),
    .a_gt_b (unused_gt_min),
    .a_lt_b (din_lt_min)
  );

  // First operand seeds both results; afterwards strict compares keep ties.
  assign upd_max = (cnt == '0) || din_gt_max;
  assign upd_min = (cnt == '0) || din_lt_min;

  // One-hot flop bits double as registered status outputs.
  assign state     = state_q;
  assign din_ready = state_q[1];
  assign busy      = state_q[1];
  assign done      = state_q[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      max     <= '0;
      min     <= '0;
      cnt     <= '0;
`ifdef MAX_MIN_INDEX_EN
      max_idx <= '0;
      min_idx <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_SCAN;
            cnt     <= '0;
          end
        end
        S_SCAN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (din_valid) begin
            if (upd_max) begin
              max <= din;
`ifdef MAX_MIN_INDEX_EN
              max_idx <= cnt[$clog2(N)-1:0];
`endif
            end
            if (upd_min) begin
              min <= din;
`ifdef MAX_MIN_INDEX_EN
              min_idx <= cnt[$clog2(N)-1:0];
`endif
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (abort || ack) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_min_n_finder.sv
// Directed bench: three instances (3x3 unsigned, 4x4 signed, 4x4 unsigned).
module tb_max_min_n_finder;
  import max_min_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] start, ack, abort, dv;
  logic [2:0][3:0] din;

  wire [2:0][3:0] mx, mn;
  wire [2:0][2:0] cn, st;
  wire [2:0]      rdy, bsy, dn;
`ifdef MAX_MIN_INDEX_EN
  wire [2:0][1:0] mxi, mni;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mx[0][3] = 1'b0;
  assign mn[0][3] = 1'b0;

  max_min_n_finder #(.W(3), .N(3), .SIGNED(0)) u_d0 (
    .clk(clk), .reset(reset), .start(start[0]), .ack(ack[0]), .abort(abort[0]),
    .din_valid(dv[0]), .din(din[0][2:0]), .din_ready(rdy[0]),
    .max(mx[0][2:0]), .min(mn[0][2:0]), .cnt(cn[0]), .busy(bsy[0]), .done(dn[0]),
`ifdef MAX_MIN_INDEX_EN
    .max_idx(mxi[0]), .min_idx(mni[0]),
`endif
    .state(st[0]));

  max_min_n_finder #(.W(4), .N(4), .SIGNED(1)) u_d1 (
    .clk(clk), .reset(reset), .start(start[1]), .ack(ack[1]), .abort(abort[1]),
    .din_valid(dv[1]), .din(din[1]), .din_ready(rdy[1]),
    .max(mx[1]), .min(mn[1]), .cnt(cn[1]), .busy(bsy[1]), .done(dn[1]),
`ifdef MAX_MIN_INDEX_EN
    .max_idx(mxi[1]), .min_idx(mni[1]),
`endif
    .state(st[1]));

  max_min_n_finder #(.W(4), .N(4), .SIGNED(0)) u_d2 (
    .clk(clk), .reset(reset), .start(start[2]), .ack(ack[2]), .abort(abort[2]),
    .din_valid(dv[2]), .din(din[2]), .din_ready(rdy[2]),
    .max(mx[2]), .min(mn[2]), .cnt(cn[2]), .busy(bsy[2]), .done(dn[2]),
`ifdef MAX_MIN_INDEX_EN
    .max_idx(mxi[2]), .min_idx(mni[2]),
`endif
    .state(st[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic push(input int d, input logic [3:0] v);
    dv[d]  = 1'b1;
    din[d] = v;
    tick();
    dv[d]  = 1'b0;
  endtask

  task automatic release_ack(input int d);
    ack[d] = 1'b1;
    tick();
    ack[d] = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = '0; ack = '0; abort = '0; dv = '0; din = '0;
    tick(); tick();
    chk("rst_state", st[0], ST_IDLE);
    chk("rst_max",   mx[0], 0);
    chk("rst_min",   mn[0], 0);
    chk("rst_cnt",   cn[0], 0);
    chk("rst_flags", {rdy[0], bsy[0], dn[0]}, 3'b000);
    reset = 1'b1;
    tick();

    // 3x3 unsigned: 5, 2, 7
    go(0);
    chk("t1_scan",  st[0], ST_SCAN);
    chk("t1_busy",  {rdy[0], bsy[0], dn[0]}, 3'b110);
    push(0, 4'd5);
    chk("t1_first", {mx[0], mn[0]}, {4'd5, 4'd5});
    push(0, 4'd2);
    chk("t1_cnt2",  cn[0], 2);
    chk("t1_notdone", dn[0], 0);
    push(0, 4'd7);
    chk("t1_done",  st[0], ST_DONE);
    chk("t1_flags", {rdy[0], bsy[0], dn[0]}, 3'b001);
    chk("t1_res",   {mx[0], mn[0], 1'b0, cn[0]}, {4'd7, 4'd2, 4'd3});
    release_ack(0);
    chk("t1_idle",  st[0], ST_IDLE);
    chk("t1_hold",  {mx[0], mn[0]}, {4'd7, 4'd2});

    // Same operands signed vs unsigned
    start[1] = 1'b1; start[2] = 1'b1;
    tick();
    start[1] = 1'b0; start[2] = 1'b0;
    dv[1] = 1'b1; dv[2] = 1'b1;
    din[1] = 4'hD; din[2] = 4'hD; tick();
    din[1] = 4'h5; din[2] = 4'h5; tick();
    din[1] = 4'h8; din[2] = 4'h8; tick();
    din[1] = 4'h2; din[2] = 4'h2; tick();
    dv[1] = 1'b0; dv[2] = 1'b0;
    chk("t2_s_done", dn[1], 1);
    chk("t2_s_res",  {mx[1], mn[1]}, {4'h5, 4'h8});
    chk("t2_u_done", dn[2], 1);
    chk("t2_u_res",  {mx[2], mn[2]}, {4'hD, 4'h2});
    chk("t2_u_cnt",  cn[2], 4);
    ack[1] = 1'b1; ack[2] = 1'b1;
    tick();
    ack[1] = 1'b0; ack[2] = 1'b0;
    chk("t2_idle", {st[1], st[2]}, {ST_IDLE, ST_IDLE});

    // Operands in IDLE are ignored
    push(2, 4'hF);
    chk("t3_idle_rdy",  rdy[2], 0);
    chk("t3_idle_hold", {mx[2], mn[2], 1'b0, cn[2]}, {4'hD, 4'h2, 4'd4});

    // Valid gaps: 3, _, 3, _, _, 1, 6
    go(2);
    chk("t3_cnt0", cn[2], 0);
    push(2, 4'd3);
    din[2] = 4'hF; tick();
    chk("t3_gap", {cn[2], mx[2]}, {3'd1, 4'd3});
    push(2, 4'd3);
    din[2] = 4'h0; tick(); tick();
    chk("t3_gap2", cn[2], 2);
    push(2, 4'd1);
    chk("t3_notdone", dn[2], 0);
    push(2, 4'd6);
    chk("t3_done", dn[2], 1);
    chk("t3_res",  {mx[2], mn[2]}, {4'd6, 4'd1});
    push(2, 4'hF);
    push(2, 4'h0);
    chk("t3_done_hold", {rdy[2], dn[2], cn[2], mx[2], mn[2]}, {1'b0, 1'b1, 3'd4, 4'd6, 4'd1});
    release_ack(2);

    // Ties keep the earlier operand: 4, 7, 7, 1
    go(2);
    push(2, 4'd4);
    push(2, 4'd7);
    push(2, 4'd7);
    push(2, 4'd1);
    chk("t6_res", {mx[2], mn[2]}, {4'd7, 4'd1});
`ifdef MAX_MIN_INDEX_EN
    chk("t6_max_idx", mxi[2], 1);
    chk("t6_min_idx", mni[2], 3);
`endif
    release_ack(2);

    // Abort after 1 accept, with a concurrent operand that must be dropped
    go(1);
    push(1, 4'd4);
    abort[1] = 1'b1; dv[1] = 1'b1; din[1] = 4'h7;
    tick();
    abort[1] = 1'b0; dv[1] = 1'b0;
    chk("t5_abort_st",  st[1], ST_IDLE);
    chk("t5_abort_val", {cn[1], mx[1], mn[1]}, {3'd1, 4'd4, 4'd4});
    tick(); tick();
    chk("t5_no_done", dn[1], 0);

    // start and ack together in DONE: ack wins, no new run
    go(0);
    push(0, 4'd1);
    push(0, 4'd6);
    push(0, 4'd3);
    chk("t5_d0_res", {dn[0], mx[0], mn[0]}, {1'b1, 4'd6, 4'd1});
    start[0] = 1'b1; ack[0] = 1'b1;
    tick();
    start[0] = 1'b0; ack[0] = 1'b0;
    chk("t5_sa_idle", st[0], ST_IDLE);
    tick();
    chk("t5_sa_norun", {st[0], bsy[0]}, {ST_IDLE, 1'b0});

    // Asynchronous reset mid-scan after 2 accepts
    go(2);
    push(2, 4'd9);
    push(2, 4'd3);
    chk("t4_pre", cn[2], 2);
    #2 reset = 1'b0;
    #1;
    chk("t4_rst_st",  st[2], ST_IDLE);
    chk("t4_rst_val", {cn[2], mx[2], mn[2]}, 11'd0);
    #1 reset = 1'b1;
    tick();
    go(2);
    push(2, 4'd2);
    push(2, 4'd4);
    push(2, 4'd1);
    push(2, 4'd3);
    chk("t4_rerun", {dn[2], cn[2], mx[2], mn[2]}, {1'b1, 3'd4, 4'd4, 4'd1});
    release_ack(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
